piso_chain_reader: RTL and testbench

//  Downstream controller for a daisy chain of HC1645 8-bit PISO registers.
//  - Generates the chain's active-low parallel-load strobe (shld) and serial clock.
//  - Samples the chain's serial output q.
//  - Assembles one parallel word per scan.
//  - Presents the word on a valid/ready interface to the consumer logic.

---
 rtl/piso_chain_reader.sv | 163 ++++++++++++++++
 tb/tb_piso_chain_reader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_chain_reader.sv
`default_nettype none
// ============================================================================
//  Module   : piso_chain_reader
//  Purpose  : Controller for a daisy chain of HC1645 8-bit PISO registers.
//             Drives the active-low parallel-load strobe and the serial clock,
//             samples the chain output MSB first, and presents each assembled
//             word on a valid/ready interface.
//  Options  : PISO_READER_AUTOSCAN_EN - when defined, start is ignored and a
//             new scan begins whenever the reader is idle and the output
//             register is free (or being accepted on the same edge).
//  Revision : 1.0 - initial release
// ============================================================================
module piso_chain_reader #(
    parameter int NUM_CHIPS = 1,
    parameter int CLK_DIV   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   ser_q,
    output logic                   sr_clk,
    output logic                   sr_shld,
    output logic [8*NUM_CHIPS-1:0] data,
    output logic                   valid,
    input  logic                   ready,
    output logic                   busy
);

    localparam int W  = 8 * NUM_CHIPS;
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(W + 1);

    localparam logic [PW-1:0] c_PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] c_BIT_LAST = BW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_HIGH   = 3'd3,
        S_LOW    = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [PW-1:0]  r_phase;
    logic [BW-1:0]  r_bits;
    logic [W-1:0]   r_sreg;
    logic [W-1:0]   r_data;
    logic           r_valid;
    logic           r_sr_clk;
    logic           r_sr_shld;

    logic           w_req;
    logic           w_accept;
    logic           w_phase_done;
    logic           w_sample;
    logic           w_last;
    logic [W-1:0]   w_sreg_next;
    logic           w_sr_clk_d;
    logic           w_sr_shld_d;

`ifdef PISO_READER_AUTOSCAN_EN
    // Free-running scans: the request input has no effect in this build.
    logic w_unused_start;
    assign w_unused_start = start;
    assign w_req          = 1'b1;
`else
    assign w_req          = start;
`endif

    // A scan may begin only if the output register is empty or is being
    // handed over on this very edge, so an unaccepted word is never lost.
    assign w_accept     = (r_state == S_IDLE) && w_req && (!r_valid || ready);
    assign w_phase_done = (r_phase == c_PH_LAST);
    assign w_sample     = w_phase_done && ((r_state == S_SETTLE) || (r_state == S_LOW));
    assign w_last       = w_sample && (r_bits == c_BIT_LAST);
    assign w_sreg_next  = {r_sreg[W-2:0], ser_q};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and the serial strobe levels for the next state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)     w_next = S_LOAD;
            S_LOAD:   if (w_phase_done) w_next = S_SETTLE;
            S_SETTLE: if (w_sample)     w_next = w_last ? S_IDLE : S_HIGH;
            S_HIGH:   if (w_phase_done) w_next = S_LOW;
            S_LOW:    if (w_sample)     w_next = w_last ? S_IDLE : S_HIGH;
            default:                    w_next = S_IDLE;
        endcase
        w_sr_clk_d  = (w_next == S_HIGH);
        w_sr_shld_d = (w_next != S_LOAD);
    end

    // Phase timer: restarts on every state change, idles at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
        end else if ((r_state == S_IDLE) || (w_next != r_state)) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    // Sample counter: cleared when a scan is accepted, bumped per sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bits <= '0;
        end else if (w_accept) begin
            r_bits <= '0;
        end else if (w_sample) begin
            r_bits <= r_bits + 1'b1;
        end
    end

    // Serial assembly, output word capture and the valid handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_sample) begin
                r_sreg <= w_sreg_next;
            end
            if (w_last) begin
                r_data  <= w_sreg_next;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Registered chain strobes, aligned with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr_clk  <= 1'b0;
            r_sr_shld <= 1'b1;
        end else begin
            r_sr_clk  <= w_sr_clk_d;
            r_sr_shld <= w_sr_shld_d;
        end
    end

    assign sr_clk  = r_sr_clk;
    assign sr_shld = r_sr_shld;
    assign data    = r_data;
    assign valid   = r_valid;
    assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_piso_chain_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_chain_reader
//  Purpose  : Self-checking bench for piso_chain_reader. Two readers are
//             exercised (1 chip / divide 2 and 2 chips / divide 1), each
//             attached to a behavioural HC1645 chain model; expected words
//             are queued at scan issue and checked by independent monitors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_piso_chain_reader;

    localparam int NA = 1, CA = 2, WA = 8,  LATA = 2 * WA * CA;
    localparam int NB = 2, CB = 1, WB = 16, LATB = 2 * WB * CB;

    typedef struct {
        logic [15:0] w;
        int          e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reader A ----------------
    logic          a_start = 1'b0, a_ready = 1'b1, a_q;
    logic          a_sclk, a_shld, a_valid, a_busy;
    logic [WA-1:0] a_data;
    logic [WA-1:0] a_par = '0, a_chain = '0;
    int            a_ld = 0, a_rise = 0, a_vrise = 0;
    exp_t          qa[$];

    piso_chain_reader #(.NUM_CHIPS(NA), .CLK_DIV(CA)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .ser_q(a_q),
        .sr_clk(a_sclk), .sr_shld(a_shld), .data(a_data),
        .valid(a_valid), .ready(a_ready), .busy(a_busy)
    );

    // ---------------- reader B ----------------
    logic          b_start = 1'b0, b_ready = 1'b1, b_q;
    logic          b_sclk, b_shld, b_valid, b_busy;
    logic [WB-1:0] b_data;
    logic [WB-1:0] b_par = '0, b_chain = '0;
    int            b_ld = 0, b_rise = 0;
    exp_t          qb[$];

    piso_chain_reader #(.NUM_CHIPS(NB), .CLK_DIV(CB)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .ser_q(b_q),
        .sr_clk(b_sclk), .sr_shld(b_shld), .data(b_data),
        .valid(b_valid), .ready(b_ready), .busy(b_busy)
    );

    assign a_q = a_chain[WA-1];
    assign b_q = b_chain[WB-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // HC1645 chain models: load while shld low, shift on each sr_clk rise.
    initial begin : chain_a
        logic ps;
        ps = 1'b0;
        forever begin
            @(negedge clk);
            if (!a_shld) begin
                a_chain = a_par;
                a_ld++;
            end else if (a_sclk && !ps) begin
                a_chain = a_chain << 1;
                a_rise++;
            end
            ps = a_sclk;
        end
    end

    initial begin : chain_b
        logic ps;
        ps = 1'b0;
        forever begin
            @(negedge clk);
            if (!b_shld) begin
                b_chain = b_par;
                b_ld++;
            end else if (b_sclk && !ps) begin
                b_chain = b_chain << 1;
                b_rise++;
            end
            ps = b_sclk;
        end
    end

    // Monitors: each new valid pops one expected word; data must hold while valid.
    initial begin : mon_a
        logic pv;
        logic [WA-1:0] held;
        exp_t e;
        pv = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (a_valid && !pv) begin
                    a_vrise++;
                    if (qa.size() == 0) begin
                        chk("a_unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        e = qa.pop_front();
                        chk("a_data", 32'(a_data), 32'(e.w));
                        chk("a_latency", 32'(cyc - e.e), 32'(LATA));
                    end
                end else if (a_valid && pv) begin
                    chk("a_hold", 32'(a_data), 32'(held));
                end
                pv = a_valid;
                held = a_data;
            end
        end
    end

    initial begin : mon_b
        logic pv;
        exp_t e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (b_valid && !pv) begin
                    if (qb.size() == 0) begin
                        chk("b_unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        e = qb.pop_front();
                        chk("b_data", 32'(b_data), 32'(e.w));
                        chk("b_latency", 32'(cyc - e.e), 32'(LATB));
                    end
                end
                pv = b_valid;
            end
        end
    end

    // Issue a one-cycle start on A; the next edge accepts it.
    task automatic scan_a(input logic [WA-1:0] w, output int acc);
        @(negedge clk);
        a_par = w;
        a_start = 1'b1;
        acc = cyc + 1;
        qa.push_back('{w: 16'(w), e: acc});
        a_ld = 0;
        a_rise = 0;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic scan_b(input logic [WB-1:0] w, output int acc);
        @(negedge clk);
        b_par = w;
        b_start = 1'b1;
        acc = cyc + 1;
        qb.push_back('{w: w, e: acc});
        b_ld = 0;
        b_rise = 0;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin : stim
        int acc, v0;
        logic [WA-1:0] w;
        logic [WB-1:0] wb;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_sclk",  32'(a_sclk),  32'd0);
        chk("rst_shld",  32'(a_shld),  32'd1);
        chk("rst_data",  32'(a_data),  32'd0);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_busy",  32'(a_busy),  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single scan of 0xA5 with ready high.
        scan_a(8'hA5, acc);
        chk("t1_busy", 32'(a_busy), 32'd1);
        wait_until(acc + LATA);
        chk("t1_valid", 32'(a_valid), 32'd1);
        chk("t1_shld_cycles", 32'(a_ld), 32'(CA));
        chk("t1_sclk_rises", 32'(a_rise), 32'(WA - 1));
        @(negedge clk);
        chk("t1_valid_drop", 32'(a_valid), 32'd0);

        // Back-pressure: word held, starts ignored, then released.
        a_ready = 1'b0;
        scan_a(8'hA5, acc);
        wait_until(acc + LATA);
        for (int i = 0; i < 5; i++) begin
            repeat (9) @(negedge clk);
            a_start = 1'b1;
            @(negedge clk);
            a_start = 1'b0;
        end
        chk("t2_valid_held", 32'(a_valid), 32'd1);
        chk("t2_data_held", 32'(a_data), 32'hA5);
        chk("t2_busy_ignored", 32'(a_busy), 32'd0);
        a_ready = 1'b1;
        @(negedge clk);
        chk("t2_valid_drop", 32'(a_valid), 32'd0);
        chk("t2_no_rescan", 32'(a_busy), 32'd0);

        // Back-to-back scans with start and ready held high.
        @(negedge clk);
        a_par = 8'h3C;
        a_start = 1'b1;
        acc = cyc + 1;
        qa.push_back('{w: 16'h3C, e: acc});
        qa.push_back('{w: 16'hC3, e: acc + LATA + 1});
        repeat (10) @(negedge clk);
        a_par = 8'hC3;
        wait_until(acc + LATA + 1);
        chk("t3_valid_width", 32'(a_valid), 32'd0);
        chk("t3_rescan_busy", 32'(a_busy), 32'd1);
        wait_until(acc + 2 * LATA + 1);
        a_start = 1'b0;
        @(negedge clk);
        chk("t3_valid_width2", 32'(a_valid), 32'd0);
        chk("t3_idle", 32'(a_busy), 32'd0);

        // Reset mid-scan aborts cleanly.
        scan_a(8'(($urandom)), acc);
        wait_until(acc + 9);
        rst = 1'b1;
        #1;
        chk("t4_sclk",  32'(a_sclk),  32'd0);
        chk("t4_shld",  32'(a_shld),  32'd1);
        chk("t4_valid", 32'(a_valid), 32'd0);
        chk("t4_busy",  32'(a_busy),  32'd0);
        chk("t4_data",  32'(a_data),  32'd0);
        qa.delete();
        @(negedge clk);
        rst = 1'b0;
        v0 = a_vrise;
        repeat (40) @(negedge clk);
        chk("t4_no_valid", 32'(a_vrise), 32'(v0));
        scan_a(8'(($urandom)), acc);
        wait_until(acc + LATA + 1);

        // Random words with back-pressure and simultaneous ready+start.
        for (int i = 0; i < 6; i++) begin
            a_ready = 1'b0;
            scan_a(8'($urandom), acc);
            wait_until(acc + LATA + int'($urandom_range(0, 5)));
            w = 8'($urandom);
            a_par = w;
            a_ready = 1'b1;
            a_start = 1'b1;
            acc = cyc + 1;
            qa.push_back('{w: 16'(w), e: acc});
            @(negedge clk);
            a_start = 1'b0;
            a_ready = 1'b0;
            chk("r_handover", 32'(a_valid), 32'd0);
            wait_until(acc + LATA);
            a_ready = 1'b1;
            @(negedge clk);
        end

        // Two-chip reader, divide by one.
        scan_b(16'hBEEF, acc);
        wait_until(acc + LATB);
        chk("t5_sclk_rises", 32'(b_rise), 32'(WB - 1));
        chk("t5_shld_cycles", 32'(b_ld), 32'(CB));
        for (int i = 0; i < 4; i++) begin
            wb = 16'($urandom);
            scan_b(wb, acc);
            wait_until(acc + LATB + 1);
        end

        repeat (5) @(negedge clk);
        chk("a_sb_drained", 32'(qa.size()), 32'd0);
        chk("b_sb_drained", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
